pipe_issue_ctrl: RTL and testbench
==================================

# pipe_issue_ctrl

Issue controller for the 4-stage register/memory datapath. Buffers incoming instruction words in a small FIFO, checks each head instruction against a scoreboard of in-flight register writes, and presents one instruction per cycle to the datapath's operand-fetch stage. An instruction is held only when it reads a register still awaiting write-back. Illegal function codes are dropped and counted.

## Interface
Parameters:
- FIFO_DEPTH, 4: instruction buffer entries; power of two, at least 2.
- WB_LAT, 3: cycles from the issue edge until the issued rd is readable from the regbank; at least 1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  producer has an instruction on in_instr.
- in_ready  out  1  buffer can accept; transfer on in_valid && in_ready at a rising edge.
- in_instr  in  24  instruction word: [23:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr.
- iss_valid  out  1  one-cycle strobe; iss_* fields are valid this cycle.
- iss_func, iss_rd, iss_rs1, iss_rs2  out  4 each  issued fields.
- iss_addr  out  8  issued memory address.
- stall  out  1  head is legal and blocked by a hazard this cycle.
- busy  out  1  FIFO non-empty or any scoreboard slot valid.
- illegal_cnt  out  8  count of dropped illegal instructions; saturates at 255.
- issue_cnt  out  16  count of issued instructions; wraps.

## Operation
- FIFO: in_ready = (count != FIFO_DEPTH), derived from registered count.
  - Enqueue and dequeue may occur on the same edge.
  - When full, in_ready stays 0 even if a dequeue happens on that edge.
- Operand use, decided per func:
  - 0,1,2,5,6,7 read rs1 and rs2.
  - 3,8,10,11 read rs1 only.
  - 4,9 read rs2 only.
  - 12–15 are illegal.
- Scoreboard: a shift register of WB_LAT slots, each {valid, rd}.
  - Every edge, slot k moves to slot k+1 and the last slot is discarded.
  - Slot 0 loads {1, rd} when an instruction issues on that edge, otherwise {0, x}.
- hazard = head valid and any valid slot's rd equals a *used* head source register.
- Head decision each cycle (exactly one applies):
  - FIFO empty: idle.
  - Illegal func: pop, no issue, illegal_cnt +1 (saturating), no scoreboard entry.
  - Legal and hazard: hold; stall=1.
  - Legal and no hazard: pop, register fields onto iss_*, iss_valid=1 next cycle, issue_cnt +1, load slot 0.
- No WAW or WAR checks. Write-back is in order with a fixed latency, and memory is write-only from the datapath.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - FIFO empty, scoreboard cleared.
  - iss_valid=0 and all iss_* fields 0.
  - stall=0, busy=0, counters 0, in_ready=1 once reset releases.
- Reset mid-operation discards all queued and in-flight tracking. No partial issue may appear after rst asserts.
- Latency:
  - Word accepted at edge N is the head from cycle N+1.
  - Earliest issue edge is N+1, so iss_valid is high during cycle N+1..N+2.
- Dependent spacing: if the producer issues at edge E, the earliest consumer issue is edge E+WB_LAT. Independent instructions issue back-to-back.
- stall and busy are combinational from registered state. in_ready is registered-state derived and has no combinational path from in_valid.
- iss_valid never stays high two consecutive cycles for the same instruction.
- An illegal drop consumes one head cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - Field offset/width constants for the 24-bit word.
  - func code constants (ADD=0 … SHL=11).
  - The uses_rs1/uses_rs2/is_legal functions.
  The datapath decode and the bench share these.
- Sub-module pipe_instr_fifo: parameterised synchronous FIFO with count output and asynchronous active-high reset.
- Scoreboard, hazard compare, counters and issue register live in the top module.

## Test plan
- Independent stream: enqueue ADD r1←r2,r3; SUB r4←r5,r6; OR r7←r8,r9 on consecutive edges -> iss_valid on 3 consecutive cycles, stall never 1, issue_cnt=3.
- RAW stall: ADD r1←r2,r3 then SUB r4←r1,r5 with WB_LAT=3 -> SUB issues exactly 3 edges after ADD, stall=1 for 2 cycles.
- Operand-use masking: MOVA (func 3) r6←r1 with rs2=r9, issued one cycle after a write to r9 -> no stall. The same case with func 4 -> stalls until r9 retires.
- Illegal func 13 between two ADDs -> dropped, illegal_cnt=1, one idle issue cycle, no scoreboard entry. Drive 300 illegals -> illegal_cnt holds 255.
- Full FIFO: stall the head and present 6 words -> in_ready falls after 4 accepts and rises the cycle after the first pop. No word is lost or duplicated, and order is preserved.
- Reset mid-stall: assert rst while the FIFO holds 3 entries and the scoreboard has 2 valid slots -> all outputs 0 immediately. After release, a new ADD r1←r1,r1 issues with no stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 24-bit instruction word: field layout, function
// codes and the operand-use decode used by the issue controller and datapath.
package pipe_ctrl_pkg;

    localparam int INSTR_W  = 24;
    localparam int REG_W    = 4;
    localparam int FUNC_W   = 4;
    localparam int ADDR_W   = 8;
    localparam int FUNC_LSB = 20;
    localparam int RD_LSB   = 16;
    localparam int RS1_LSB  = 12;
    localparam int RS2_LSB  = 8;
    localparam int ADDR_LSB = 0;

    localparam logic [FUNC_W-1:0] FN_ADD  = 4'd0;
    localparam logic [FUNC_W-1:0] FN_SUB  = 4'd1;
    localparam logic [FUNC_W-1:0] FN_AND  = 4'd2;
    localparam logic [FUNC_W-1:0] FN_MOVA = 4'd3;
    localparam logic [FUNC_W-1:0] FN_MOVB = 4'd4;
    localparam logic [FUNC_W-1:0] FN_OR   = 4'd5;
    localparam logic [FUNC_W-1:0] FN_XOR  = 4'd6;
    localparam logic [FUNC_W-1:0] FN_CMP  = 4'd7;
    localparam logic [FUNC_W-1:0] FN_LD   = 4'd8;
    localparam logic [FUNC_W-1:0] FN_ST   = 4'd9;
    localparam logic [FUNC_W-1:0] FN_SHR  = 4'd10;
    localparam logic [FUNC_W-1:0] FN_SHL  = 4'd11;

    function automatic logic is_legal(input logic [FUNC_W-1:0] func);
        return func <= FN_SHL;
    endfunction

    function automatic logic uses_rs1(input logic [FUNC_W-1:0] func);
        case (func)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_CMP,
            FN_MOVA, FN_LD, FN_SHR, FN_SHL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [FUNC_W-1:0] func);
        case (func)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_CMP,
            FN_MOVB, FN_ST: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_instr_fifo.sv
// Synchronous FIFO with occupancy count; the caller guarantees no push when
// full and no pop when empty.
module pipe_instr_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller: buffers instructions, holds the head on a RAW hazard
// against in-flight writes, drops illegal codes and issues one per cycle.
module pipe_issue_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WB_LAT     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    output logic                iss_valid,
    output logic [FUNC_W-1:0]   iss_func,
    output logic [REG_W-1:0]    iss_rd,
    output logic [REG_W-1:0]    iss_rs1,
    output logic [REG_W-1:0]    iss_rs2,
    output logic [ADDR_W-1:0]   iss_addr,
    output logic                stall,
    output logic                busy,
    output logic [7:0]          illegal_cnt,
    output logic [15:0]         issue_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]      fifo_count;
    logic [INSTR_W-1:0] head;
    logic               head_valid;
    logic               push;
    logic               pop;
    logic               issue;
    logic               drop;
    logic               legal;
    logic               hazard;

    logic [FUNC_W-1:0]  head_func;
    logic [REG_W-1:0]   head_rd;
    logic [REG_W-1:0]   head_rs1;
    logic [REG_W-1:0]   head_rs2;
    logic [ADDR_W-1:0]  head_addr;

    logic [WB_LAT-1:0]  sb_valid;
    logic [REG_W-1:0]   sb_rd [WB_LAT];

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on registered occupancy, never on in_valid.
    assign in_ready = !rst && (fifo_count != CW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;

    pipe_instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_instr),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count)
    );

    assign head_valid = (fifo_count != '0);
    assign head_func  = head[FUNC_LSB +: FUNC_W];
    assign head_rd    = head[RD_LSB   +: REG_W];
    assign head_rs1   = head[RS1_LSB  +: REG_W];
    assign head_rs2   = head[RS2_LSB  +: REG_W];
    assign head_addr  = head[ADDR_LSB +: ADDR_W];
    assign legal      = is_legal(head_func);

    // The oldest slot's write lands on the edge a consumer would issue, so it
    // no longer blocks; it is kept only so busy covers the full write-back.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < WB_LAT; k++) begin
            if ((k < WB_LAT - 1) && sb_valid[k] &&
                ((uses_rs1(head_func) && (sb_rd[k] == head_rs1)) ||
                 (uses_rs2(head_func) && (sb_rd[k] == head_rs2)))) begin
                hazard = 1'b1;
            end
        end
    end

    assign issue = head_valid && legal && !hazard;
    assign drop  = head_valid && !legal;
    assign pop   = issue || drop;
    assign stall = head_valid && legal && hazard;
    assign busy  = head_valid || (|sb_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < WB_LAT; k++) begin
                sb_valid[k] <= 1'b0;
                sb_rd[k]    <= '0;
            end
        end else begin
            for (int k = WB_LAT - 1; k > 0; k--) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
            sb_valid[0] <= issue;
            sb_rd[0]    <= issue ? head_rd : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid   <= 1'b0;
            iss_func    <= '0;
            iss_rd      <= '0;
            iss_rs1     <= '0;
            iss_rs2     <= '0;
            iss_addr    <= '0;
            illegal_cnt <= '0;
            issue_cnt   <= '0;
        end else begin
            iss_valid <= issue;
            if (issue) begin
                iss_func  <= head_func;
                iss_rd    <= head_rd;
                iss_rs1   <= head_rs1;
                iss_rs2   <= head_rs2;
                iss_addr  <= head_addr;
                issue_cnt <= issue_cnt + 16'd1;
            end
            if (drop && (illegal_cnt != 8'hFF)) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: one task per scenario, each with its
// own hand-computed expectations.
module tb_pipe_issue_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_instr = '0;
    logic        iss_valid;
    logic [3:0]  iss_func, iss_rd, iss_rs1, iss_rs2;
    logic [7:0]  iss_addr;
    logic        stall, busy;
    logic [7:0]  illegal_cnt;
    logic [15:0] issue_cnt;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_issue_ctrl #(.FIFO_DEPTH(4), .WB_LAT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .iss_valid(iss_valid), .iss_func(iss_func),
        .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_addr(iss_addr), .stall(stall), .busy(busy),
        .illegal_cnt(illegal_cnt), .issue_cnt(issue_cnt)
    );

    function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [7:0] addr);
        return {f, rd, rs1, rs2, addr};
    endfunction

    // Leaves the bench 1 time unit after a rising edge with an idle DUT.
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL reset_iss_valid: got %0b expected 0", iss_valid); end
        tests++; if ({iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr} !== 24'h0) begin fails++; $display("FAIL reset_iss_fields: got %0h expected 0", {iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr}); end
        tests++; if (stall !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_stall_busy: got %0b%0b expected 00", stall, busy); end
        tests++; if (illegal_cnt !== 8'd0 || issue_cnt !== 16'd0) begin fails++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", illegal_cnt, issue_cnt); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_held: got %0b expected 0", in_ready); end
        do_reset();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_release: got %0b expected 1", in_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy_release: got %0b expected 0", busy); end
    endtask

    task automatic test_independent();
        logic [23:0] w[3];
        int iv_exp[6] = '{0, 1, 1, 1, 0, 0};
        do_reset();
        w[0] = mk(FN_ADD, 4'd1, 4'd2, 4'd3, 8'h10);
        w[1] = mk(FN_SUB, 4'd4, 4'd5, 4'd6, 8'h11);
        w[2] = mk(FN_OR,  4'd7, 4'd8, 4'd9, 8'h12);
        exp_q.push_back(4'd1); exp_q.push_back(4'd4); exp_q.push_back(4'd7);
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin in_valid = 1'b1; in_instr = w[c]; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
            tests++; if (iss_valid !== iv_exp[c][0]) begin fails++; $display("FAIL indep_iss_valid c%0d: got %0b expected %0d", c, iss_valid, iv_exp[c]); end
            tests++; if (stall !== 1'b0) begin fails++; $display("FAIL indep_stall c%0d: got %0b expected 0", c, stall); end
            if (iv_exp[c] == 1) begin
                logic [3:0] e;
                e = exp_q.pop_front();
                tests++; if (iss_rd !== e) begin fails++; $display("FAIL indep_rd c%0d: got %0d expected %0d", c, iss_rd, e); end
            end
        end
        tests++; if (iss_func !== FN_OR || iss_addr !== 8'h12) begin fails++; $display("FAIL indep_last_fields: got %0h/%0h expected 5/12", iss_func, iss_addr); end
        tests++; if (issue_cnt !== 16'd3) begin fails++; $display("FAIL indep_issue_cnt: got %0d expected 3", issue_cnt); end
        repeat (2) @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL indep_busy_drain: got %0b expected 0", busy); end
    endtask

    // Producer writes r_dep, consumer with func f reads it; returns nothing,
    // expectations chosen by whether f actually reads the dependent register.
    task automatic test_dependency(input string name, input logic [23:0] prod,
                                   input logic [23:0] cons, input logic dep);
        int iv_dep[7] = '{0, 1, 0, 0, 1, 0, 0};
        int st_dep[7] = '{0, 1, 1, 0, 0, 0, 0};
        int iv_ind[7] = '{0, 1, 1, 0, 0, 0, 0};
        int iv, st;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin in_valid = 1'b1; in_instr = prod; end
            else if (c == 1) begin in_valid = 1'b1; in_instr = cons; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
            iv = dep ? iv_dep[c] : iv_ind[c];
            st = dep ? st_dep[c] : 0;
            tests++; if (iss_valid !== iv[0]) begin fails++; $display("FAIL %s_iss_valid c%0d: got %0b expected %0d", name, c, iss_valid, iv); end
            tests++; if (stall !== st[0]) begin fails++; $display("FAIL %s_stall c%0d: got %0b expected %0d", name, c, stall, st); end
        end
        tests++; if ({iss_func, iss_rd} !== cons[23:16]) begin fails++; $display("FAIL %s_cons_fields: got %0h expected %0h", name, {iss_func, iss_rd}, cons[23:16]); end
        tests++; if (issue_cnt !== 16'd2) begin fails++; $display("FAIL %s_issue_cnt: got %0d expected 2", name, issue_cnt); end
    endtask

    task automatic test_raw_and_masking();
        test_dependency("raw", mk(FN_ADD, 4'd1, 4'd2, 4'd3, 8'h0), mk(FN_SUB, 4'd4, 4'd1, 4'd5, 8'h1), 1'b1);
        test_dependency("mask_rs1only", mk(FN_ADD, 4'd9, 4'd2, 4'd3, 8'h0), mk(FN_MOVA, 4'd6, 4'd1, 4'd9, 8'h2), 1'b0);
        test_dependency("mask_rs2only", mk(FN_ADD, 4'd9, 4'd2, 4'd3, 8'h0), mk(FN_MOVB, 4'd6, 4'd1, 4'd9, 8'h3), 1'b1);
    endtask

    task automatic test_illegal();
        logic [23:0] w[3];
        int iv_exp[6] = '{0, 1, 0, 1, 0, 0};
        do_reset();
        w[0] = mk(FN_ADD, 4'd1, 4'd2, 4'd3, 8'h0);
        w[1] = mk(4'd13,  4'd8, 4'd2, 4'd3, 8'h0);
        w[2] = mk(FN_ADD, 4'd4, 4'd8, 4'd8, 8'h0);
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin in_valid = 1'b1; in_instr = w[c]; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
            tests++; if (iss_valid !== iv_exp[c][0]) begin fails++; $display("FAIL illegal_iss_valid c%0d: got %0b expected %0d", c, iss_valid, iv_exp[c]); end
            tests++; if (stall !== 1'b0) begin fails++; $display("FAIL illegal_stall c%0d: got %0b expected 0", c, stall); end
        end
        tests++; if (iss_rd !== 4'd4) begin fails++; $display("FAIL illegal_second_rd: got %0d expected 4", iss_rd); end
        tests++; if (illegal_cnt !== 8'd1) begin fails++; $display("FAIL illegal_cnt_one: got %0d expected 1", illegal_cnt); end
        tests++; if (issue_cnt !== 16'd2) begin fails++; $display("FAIL illegal_issue_cnt: got %0d expected 2", issue_cnt); end
        in_valid = 1'b1;
        in_instr = mk(4'd15, 4'd1, 4'd1, 4'd1, 8'h0);
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (c == 254) begin
                tests++; if (illegal_cnt !== 8'd254) begin fails++; $display("FAIL illegal_cnt_pre_sat: got %0d expected 254", illegal_cnt); end
            end
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        tests++; if (illegal_cnt !== 8'd255) begin fails++; $display("FAIL illegal_cnt_sat: got %0d expected 255", illegal_cnt); end
        tests++; if (issue_cnt !== 16'd2 || busy !== 1'b0) begin fails++; $display("FAIL illegal_after_flood: got cnt %0d busy %0b expected 2/0", issue_cnt, busy); end
    endtask

    // Dependency chain issues every 3 edges (2,5,8,...) while words arrive
    // every cycle, so the buffer fills and in_ready must follow occupancy.
    task automatic test_full_fifo();
        int mc = 0;
        int sent = 0;
        int npop = 0;
        logic exp_ready, drove, pop_e, exp_stall;
        do_reset();
        for (int e = 1; e <= 26; e++) begin
            exp_ready = (mc != 4);
            tests++; if (in_ready !== exp_ready) begin fails++; $display("FAIL full_in_ready e%0d: got %0b expected %0b", e, in_ready, exp_ready); end
            drove = (sent < 8);
            in_valid = drove;
            in_instr = mk(FN_ADD, 4'(sent + 1), 4'(sent), 4'(sent), 8'(sent));
            @(posedge clk); #1;
            if (drove && exp_ready) begin
                exp_q.push_back(4'(sent + 1));
                sent++;
            end
            pop_e = (npop < 8) && (e == 2 + 3 * npop);
            if (pop_e) npop++;
            mc = mc + ((drove && exp_ready) ? 1 : 0) - (pop_e ? 1 : 0);
            exp_stall = (mc > 0) && !((npop < 8) && (e + 1 == 2 + 3 * npop));
            tests++; if (iss_valid !== pop_e) begin fails++; $display("FAIL full_iss_valid e%0d: got %0b expected %0b", e, iss_valid, pop_e); end
            tests++; if (stall !== exp_stall) begin fails++; $display("FAIL full_stall e%0d: got %0b expected %0b", e, stall, exp_stall); end
            if (pop_e) begin
                logic [3:0] r;
                r = exp_q.pop_front();
                tests++; if (iss_rd !== r || iss_addr !== 8'(r - 4'd1)) begin fails++; $display("FAIL full_order e%0d: got rd %0d addr %0d expected rd %0d", e, iss_rd, iss_addr, r); end
            end
        end
        in_valid = 1'b0;
        tests++; if (issue_cnt !== 16'd8 || sent != 8) begin fails++; $display("FAIL full_totals: got issued %0d sent %0d expected 8/8", issue_cnt, sent); end
    endtask

    task automatic test_reset_mid_stall();
        logic [23:0] w[6];
        do_reset();
        w[0] = mk(FN_ADD, 4'd1, 4'd2, 4'd3, 8'h0);
        w[1] = mk(FN_ADD, 4'd4, 4'd1, 4'd1, 8'h0);
        w[2] = mk(FN_ADD, 4'd5, 4'd6, 4'd6, 8'h0);
        w[3] = mk(FN_ADD, 4'd7, 4'd4, 4'd5, 8'h0);
        w[4] = mk(FN_ADD, 4'd8, 4'd9, 4'd9, 8'h0);
        w[5] = mk(FN_ADD, 4'd10, 4'd9, 4'd9, 8'h0);
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_instr = w[c];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++; if (stall !== 1'b1 || busy !== 1'b1 || iss_valid !== 1'b1) begin fails++; $display("FAIL midrst_setup: got stall %0b busy %0b iv %0b expected 1/1/1", stall, busy, iss_valid); end
        rst = 1'b1;
        #1;
        tests++; if (iss_valid !== 1'b0 || stall !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL midrst_outputs: got iv %0b st %0b busy %0b rdy %0b expected 0", iss_valid, stall, busy, in_ready); end
        tests++; if ({iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr} !== 24'h0 || issue_cnt !== 16'd0) begin fails++; $display("FAIL midrst_fields: got %0h cnt %0d expected 0", {iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr}, issue_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %0b expected 1", in_ready); end
        in_valid = 1'b1;
        in_instr = mk(FN_ADD, 4'd1, 4'd1, 4'd1, 8'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (stall !== 1'b0 || iss_valid !== 1'b0) begin fails++; $display("FAIL midrst_head: got stall %0b iv %0b expected 0/0", stall, iss_valid); end
        @(posedge clk); #1;
        tests++; if (iss_valid !== 1'b1 || iss_rd !== 4'd1 || issue_cnt !== 16'd1) begin fails++; $display("FAIL midrst_issue: got iv %0b rd %0d cnt %0d expected 1/1/1", iss_valid, iss_rd, issue_cnt); end
        @(posedge clk); #1;
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL midrst_single_strobe: got %0b expected 0", iss_valid); end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_and_masking();
        test_illegal();
        test_full_fifo();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
